uart_cmd_parser: RTL and testbench

Frame decoder that sits directly downstream of `uart_rx` and consumes its byte strobe.
- Assembles sync/command/length/payload/checksum frames from the received byte stream.
- Validates each frame and holds its payload in an internal buffer for random-access read.
- Presents each validated command to the control logic as a single-cycle strobe.
- Reports malformed frames through an error strobe with a reason code.

---
 rtl/uart_cmd_parser.sv | 163 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames sync/cmd/len/payload/chk bytes from uart_rx,
// buffers the payload and strobes accepted commands or frame errors.
`timescale 1ns/1ps

module uart_cmd_parser #(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 1740
) (
  input  logic                      i_Clock,
  input  logic                      i_Rst_L,
  input  logic                      i_Rx_DV,
  input  logic [7:0]                i_Rx_Byte,
  output logic                      o_Cmd_DV,
  output logic [7:0]                o_Cmd,
  output logic [$clog2(MAX_LEN):0]  o_Len,
  input  logic [$clog2(MAX_LEN)-1:0] i_Rd_Addr,
  output logic [7:0]                o_Rd_Data,
  output logic                      o_Err,
  output logic [1:0]                o_Err_Code,
  output logic                      o_Busy
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [7:0]    SYNC  = 8'hA5;
  localparam logic [7:0]    MAXB  = 8'(MAX_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  state_t          state, state_n;
  logic [7:0]      cmd_q, cmd_n;
  logic [LW-1:0]   len_q, len_n;
  logic [7:0]      sum_q, sum_n;
  logic [LW-1:0]   idx_q, idx_n;
  logic [LW-1:0]   idx_inc;
  logic [TW-1:0]   tcnt;
  logic            expired;

  logic            dv_n;
  logic            err_n;
  logic [1:0]      code_n;
  logic [7:0]      ocmd_n;
  logic [LW-1:0]   olen_n;
  logic            we;

  logic [7:0]      mem [MAX_LEN];

  assign idx_inc = idx_q + LW'(1);
  assign expired = (state != S_IDLE) && (tcnt == TLAST);

  always_comb begin
    state_n = state;
    cmd_n   = cmd_q;
    len_n   = len_q;
    sum_n   = sum_q;
    idx_n   = idx_q;
    dv_n    = 1'b0;
    err_n   = 1'b0;
    code_n  = o_Err_Code;
    ocmd_n  = o_Cmd;
    olen_n  = o_Len;
    we      = 1'b0;
    if (i_Rx_DV) begin
      unique case (state)
        S_IDLE: begin
          if (i_Rx_Byte == SYNC) state_n = S_CMD;
        end
        S_CMD: begin
          cmd_n   = i_Rx_Byte;
          sum_n   = i_Rx_Byte;
          state_n = S_LEN;
        end
        S_LEN: begin
          sum_n = sum_q + i_Rx_Byte;
          len_n = i_Rx_Byte[LW-1:0];
          idx_n = '0;
          if (i_Rx_Byte > MAXB) begin
            err_n   = 1'b1;
            code_n  = 2'b10;
            state_n = S_IDLE;
          end else if (i_Rx_Byte == 8'd0) begin
            state_n = S_CHK;
          end else begin
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          we    = 1'b1;
          sum_n = sum_q + i_Rx_Byte;
          idx_n = idx_inc;
          if (idx_inc == len_q) state_n = S_CHK;
        end
        S_CHK: begin
          state_n = S_IDLE;
          if (i_Rx_Byte == sum_q) begin
            dv_n   = 1'b1;
            ocmd_n = cmd_q;
            olen_n = len_q;
          end else begin
            err_n  = 1'b1;
            code_n = 2'b01;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else if (expired) begin
      // a byte arriving on the expiry cycle takes the branch above
      err_n   = 1'b1;
      code_n  = 2'b11;
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      tcnt       <= '0;
      o_Cmd_DV   <= 1'b0;
      o_Err      <= 1'b0;
      o_Err_Code <= 2'b00;
      o_Cmd      <= '0;
      o_Len      <= '0;
      o_Busy     <= 1'b0;
      o_Rd_Data  <= '0;
    end else begin
      state      <= state_n;
      cmd_q      <= cmd_n;
      len_q      <= len_n;
      sum_q      <= sum_n;
      idx_q      <= idx_n;
      o_Cmd_DV   <= dv_n;
      o_Err      <= err_n;
      o_Err_Code <= code_n;
      o_Cmd      <= ocmd_n;
      o_Len      <= olen_n;
      o_Busy     <= (state_n != S_IDLE);
      o_Rd_Data  <= mem[i_Rd_Addr];
      if (i_Rx_DV || state == S_IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (we) mem[idx_q[AW-1:0]] <= i_Rx_Byte;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and random frames checked against
// a frame-level reference model.
`timescale 1ns/1ps

module tb_uart_cmd_parser;

  localparam int MAX_LEN = 16;
  localparam int TO      = 1740;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          cmd_dv;
  logic [7:0]    cmd;
  logic [AW:0]   len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err;
  logic [1:0]    err_code;
  logic          busy;

  int checks  = 0;
  int errors  = 0;
  int dv_cnt  = 0;
  int err_cnt = 0;

  logic          last_dv, last_err;
  logic [7:0]    m_cmd;
  logic [AW:0]   m_len;
  logic [1:0]    m_code;
  logic [7:0]    m_buf [MAX_LEN];
  logic [7:0]    fq [$];

  uart_cmd_parser #(
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_Clock(clk),
    .i_Rst_L(rst_n),
    .i_Rx_DV(rx_dv),
    .i_Rx_Byte(rx_byte),
    .o_Cmd_DV(cmd_dv),
    .o_Cmd(cmd),
    .o_Len(len),
    .i_Rd_Addr(rd_addr),
    .o_Rd_Data(rd_data),
    .o_Err(err),
    .o_Err_Code(err_code),
    .o_Busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_dv === 1'b1) dv_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    last_dv  = cmd_dv;
    last_err = err;
    rx_dv    = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    rd_addr = a[AW-1:0];
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic run_frame(input int gmax, input int stall_at,
                           input int stall);
    logic [7:0] s, d;
    int n, d0, e0;
    bit bad, ok;
    n   = int'(fq[2]);
    bad = n > MAX_LEN;
    s   = fq[1] + fq[2];
    if (!bad) for (int i = 0; i < n; i++) s = s + fq[3+i];
    ok  = !bad && (fq[fq.size()-1] == s);
    d0  = dv_cnt;
    e0  = err_cnt;
    for (int i = 0; i < fq.size(); i++) begin
      if (i > 0) idle(i == stall_at ? stall : $urandom_range(0, gmax));
      send_byte(fq[i]);
      if (i == 0) chk("busy_rise", busy, 1);
    end
    chk("cmd_dv", last_dv, ok);
    chk("err", last_err, !ok);
    chk("busy_fall", busy, 0);
    if (ok) begin
      m_cmd = fq[1];
      m_len = n[AW:0];
      for (int i = 0; i < n; i++) m_buf[i] = fq[3+i];
    end else begin
      m_code = bad ? 2'b10 : 2'b01;
    end
    chk("o_cmd", cmd, m_cmd);
    chk("o_len", len, m_len);
    chk("err_code", err_code, m_code);
    idle(1);
    chk("dv_pulses", dv_cnt - d0, ok);
    chk("err_pulses", err_cnt - e0, !ok);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        rd(i, d);
        chk("rd_data", d, m_buf[i]);
      end
    end
  endtask

  task automatic rand_frame();
    logic [7:0] c, s;
    int n;
    c = 8'($urandom);
    n = $urandom_range(0, MAX_LEN + 2);
    fq = {8'hA5, c, 8'(n)};
    s  = c + 8'(n);
    if (n <= MAX_LEN) begin
      for (int i = 0; i < n; i++) begin
        fq.push_back(8'($urandom));
        s = s + fq[3+i];
      end
      if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
      fq.push_back(s);
    end
  endtask

  initial begin
    int e0, d0, hit;
    logic [7:0] d;
    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    rd_addr = '0;
    m_cmd   = '0;
    m_len   = '0;
    m_code  = '0;
    idle(3);
    chk("rst_dv", cmd_dv, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_len", len, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    fq = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
    run_frame(3, -1, 0);
    fq = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
    run_frame(3, -1, 0);

    fq = {8'hA5, 8'h10, 8'h11};
    run_frame(3, -1, 0);
    e0 = err_cnt;
    send_byte(8'h33);
    idle(2);
    send_byte(8'h44);
    idle(2);
    chk("len_tail_err", err_cnt - e0, 0);
    chk("len_tail_busy", busy, 0);

    e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(1);
    chk("junk_err", err_cnt - e0, 0);
    chk("junk_busy", busy, 0);
    fq = {8'hA5, 8'h7F, 8'h00, 8'h7F};
    run_frame(0, -1, 0);
    fq = {8'hA5, 8'h01, 8'h01, 8'hAA, 8'hAC};
    run_frame(0, -1, 0);

    fq = {8'hA5, 8'h5C, 8'(MAX_LEN)};
    d = 8'h5C + 8'(MAX_LEN);
    for (int i = 0; i < MAX_LEN; i++) begin
      fq.push_back(8'($urandom));
      d = d + fq[3+i];
    end
    fq.push_back(d);
    run_frame(2, -1, 0);

    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h10);
    hit = 0;
    for (int k = 1; k <= 2500 && hit == 0; k++) begin
      @(negedge clk);
      if (err === 1'b1) hit = k;
    end
    m_code = 2'b11;
    chk("timeout_cycles", hit, TO);
    chk("timeout_code", err_code, m_code);
    chk("timeout_busy", busy, 0);
    idle(1);
    chk("timeout_pulses", err_cnt - e0, 1);

    fq = {8'hA5, 8'h30, 8'h01, 8'h5A, 8'h8B};
    run_frame(0, 2, TO - 1);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        e0 = err_cnt;
        send_byte(8'($urandom_range(0, 8'hA4)));
        idle(1);
        chk("rand_junk", err_cnt - e0, 0);
      end
      rand_frame();
      run_frame(3, -1, 0);
    end

    fq = {8'hA5, 8'h10, 8'h02, 8'h11};
    for (int i = 0; i < fq.size(); i++) send_byte(fq[i]);
    idle(1);
    e0 = err_cnt;
    d0 = dv_cnt;
    rst_n = 1'b0;
    idle(3);
    chk("mid_rst_dv", cmd_dv, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_code", err_code, 0);
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_len", len, 0);
    chk("mid_rst_rd", rd_data, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n  = 1'b1;
    m_cmd  = '0;
    m_len  = '0;
    m_code = '0;
    idle(2);
    chk("mid_rst_pulses", (err_cnt - e0) + (dv_cnt - d0), 0);
    fq = {8'hA5, 8'h20, 8'h00, 8'h20};
    run_frame(2, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
